operand_collector: RTL and testbench
====================================

Name: operand_collector

Overview:
- Parametrised N-slot operand capture buffer. Each accepted `put` writes `value` into the lowest empty slot.
- Once all slots are full, a selectable overflow policy applies: overwrite last slot, stall, or shift.
- Sits between the datapath producer and the multi-operand execution stage. Provides per-slot valid flags, fill count, an acknowledge pulse, a sticky overflow flag, and a `consume` handshake that empties the buffer.

Parameters:
WIDTH, 8, data width of `value` and of each slot
DEPTH, 3, number of slots (legal range 2..16)
MODE, OVF_OVERWRITE, overflow policy from `collector_pkg::ovf_mode_e`: OVF_OVERWRITE, OVF_STALL, OVF_SHIFT

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
put  input  1  offer `value` this cycle
value  input  WIDTH  data to capture
ready  output  1  combinational; 1 when a put this cycle would be accepted
consume  input  1  consumer takes the contents; all slots empty next cycle
slots  output  DEPTH*WIDTH  slot i at bits [i*WIDTH +: WIDTH], registered
slot_valid  output  DEPTH  bit i = slot i holds data
count  output  $clog2(DEPTH+1)  number of valid slots
full  output  1  count == DEPTH
done  output  1  one-cycle pulse, registered, the cycle after each accepted put
overflow  output  1  sticky; set on any put that arrives while full; cleared only by reset

Behaviour:
- Reset (synchronous, active-high; overrides everything):
  - all outputs 0: slots, slot_valid, count, done, overflow.
  - State EMPTY.
- State machine:
  - States: EMPTY (count=0), FILLING (0<count<DEPTH), FULL (count=DEPTH).
  - EMPTY -> FILLING on an accepted put.
  - FILLING -> FULL when the put fills slot DEPTH-1.
  - Any state -> EMPTY on consume without put.
  - FULL stays FULL on an overflow put.
- Accepted put, not full:
  - slot[count] <= value; slot_valid[count] <= 1; count += 1.
  - Written slot is visible the next cycle (latency 1).
- `ready`:
  - 1 in EMPTY and FILLING, and in FULL for OVF_OVERWRITE and OVF_SHIFT.
  - 0 in FULL for OVF_STALL, unless consume is also asserted that cycle.
- Put while full, without consume; count stays DEPTH:
  - OVF_OVERWRITE: slot[DEPTH-1] <= value; done pulses; overflow <= 1.
  - OVF_SHIFT: slot[i] <= slot[i+1] for i<DEPTH-1; slot[DEPTH-1] <= value; oldest value dropped; done pulses; overflow <= 1.
  - OVF_STALL: value discarded; no done; overflow <= 1.
- consume:
  - Next cycle: slot_valid=0, count=0.
  - Slot data registers are left unchanged; only the valid bits are meaningful.
- Simultaneous consume and put, any state, any MODE:
  - Clear and write in one cycle. Next cycle count=1, slot_valid=1 only for slot 0, slot[0]=value, done pulses.
  - No overflow set, even when full.
- done:
  - Goes high exactly one cycle after each accepted put; low otherwise.
  - Back-to-back puts give done high continuously.
- Reset mid-fill: contents are discarded; the next put after reset deasserts lands in slot 0.
- `full` and `count` are registered and consistent with slot_valid at all times: count = popcount(slot_valid), and valid bits are always contiguous from slot 0.

Decomposition:
- collector_pkg holds:
  - typedef enum `ovf_mode_e` {OVF_OVERWRITE, OVF_SHIFT, OVF_STALL};
  - the count-width localparam function, cnt_w(depth) = $clog2(depth+1).
- Single module.
- The per-slot register with load enable, valid bit and shift-in mux is natural as sub-module `collector_slot`. It is instantiated DEPTH times via a generate loop. The FSM and count stay in operand_collector.

Test Plan (WIDTH=8, DEPTH=3 unless noted):
- Reset, then puts 0x11, 0x22, 0x33 on consecutive cycles:
  - slots become {0x33,0x22,0x11}; count 1,2,3; full=1 after the third put.
  - done high for the 3 cycles following the puts; overflow=0.
- OVF_OVERWRITE, full, put 0x44:
  - slot2=0x44, slots 0 and 1 unchanged; count=3; done pulses; overflow=1 and stays 1 through a later consume.
- OVF_SHIFT, full {0x33,0x22,0x11}, put 0x44:
  - slots={0x44,0x33,0x22}; overflow=1.
- OVF_STALL, full, put 0x44:
  - ready=0; slots unchanged; no done; overflow=1.
  - Then consume+put 0x55 in one cycle -> count=1, slot0=0x55, slot_valid=3'b001, done pulses.
- Two puts (0xAA, 0xBB), then reset asserted one cycle, then put 0xCC:
  - After reset all outputs 0; after the put, slot0=0xCC, count=1, overflow=0.
- DEPTH=5, MODE=OVF_SHIFT, 7 puts 0x01..0x07:
  - slots={0x07,0x06,0x05,0x04,0x03}; count=5; overflow=1; done high for 7 consecutive cycles.

Source files
------------

// File: rtl/collector_pkg.sv
// Shared types and sizing helpers for the operand collector.
package collector_pkg;

  typedef enum logic [1:0] {
    OVF_OVERWRITE,
    OVF_SHIFT,
    OVF_STALL
  } ovf_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/collector_slot.sv
// One operand slot: data register with load enable, shift-in mux and valid bit.
module collector_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_value,
  input  logic [WIDTH-1:0] i_next,
  input  logic             i_set_valid,
  input  logic             i_clr_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Set wins over clear so a combined consume+put leaves slot 0 valid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) r_data <= i_shift ? i_next : i_value;
      if (i_set_valid)      r_valid <= 1'b1;
      else if (i_clr_valid) r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/operand_collector.sv
// N-slot operand capture buffer with selectable overflow policy and consume handshake.
module operand_collector
  import collector_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3,
  parameter ovf_mode_e   MODE  = OVF_OVERWRITE
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_put,
  input  logic [WIDTH-1:0]         i_value,
  output logic                     o_ready,
  input  logic                     i_consume,
  output logic [DEPTH*WIDTH-1:0]   o_slots,
  output logic [DEPTH-1:0]         o_slot_valid,
  output logic [cnt_w(DEPTH)-1:0]  o_count,
  output logic                     o_full,
  output logic                     o_done,
  output logic                     o_overflow
);

  localparam int unsigned CW = cnt_w(DEPTH);

  state_e          r_state;
  logic [CW-1:0]   r_count;
  logic            r_done;
  logic            r_overflow;

  logic             w_full;
  logic             w_accept;
  logic             w_ovf_put;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_shift;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [WIDTH-1:0] w_slot_data [DEPTH];
  logic [WIDTH-1:0] w_next_data [DEPTH];

  assign w_full    = (r_state == ST_FULL);
  assign o_ready   = !(w_full && (MODE == OVF_STALL)) || i_consume;
  assign w_accept  = i_put && o_ready;
  assign w_ovf_put = i_put && w_full && !i_consume;

  // Per-slot write/shift/valid controls.
  always_comb begin
    w_load  = '0;
    w_shift = '0;
    w_set   = '0;
    w_clr   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_consume) begin
        w_clr[i] = 1'b1;
        if (i_put && (i == 0)) begin
          w_load[i] = 1'b1;
          w_set[i]  = 1'b1;
        end
      end else if (i_put && !w_full) begin
        if (CW'(i) == r_count) begin
          w_load[i] = 1'b1;
          w_set[i]  = 1'b1;
        end
      end else if (w_ovf_put) begin
        if (MODE == OVF_OVERWRITE && i == DEPTH - 1) begin
          w_load[i] = 1'b1;
        end else if (MODE == OVF_SHIFT) begin
          w_load[i]  = 1'b1;
          w_shift[i] = 1'b1;
        end
      end
    end
  end

  // Fill-state machine with registered count, done and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_EMPTY;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_accept;
      if (w_ovf_put) r_overflow <= 1'b1;
      if (i_consume) begin
        r_count <= i_put ? CW'(1) : '0;
        r_state <= i_put ? ST_FILLING : ST_EMPTY;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (i_put) begin
              r_count <= CW'(1);
              r_state <= ST_FILLING;
            end
          end
          ST_FILLING: begin
            if (i_put) begin
              r_count <= r_count + CW'(1);
              r_state <= (r_count == CW'(DEPTH - 1)) ? ST_FULL : ST_FILLING;
            end
          end
          ST_FULL:  r_state <= ST_FULL;
          default:  r_state <= ST_EMPTY;
        endcase
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g < DEPTH - 1) begin : g_mid
      assign w_next_data[g] = w_slot_data[g+1];
    end else begin : g_last
      assign w_next_data[g] = i_value;
    end

    collector_slot #(.WIDTH(WIDTH)) u_slot (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_load      (w_load[g]),
      .i_shift     (w_shift[g]),
      .i_value     (i_value),
      .i_next      (w_next_data[g]),
      .i_set_valid (w_set[g]),
      .i_clr_valid (w_clr[g]),
      .o_data      (w_slot_data[g]),
      .o_valid     (o_slot_valid[g])
    );

    assign o_slots[g*WIDTH +: WIDTH] = w_slot_data[g];
  end

  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_operand_collector.sv
// Drives four collector configurations with shared stimulus against an array-based model.
module tb_operand_collector;
  import collector_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       put = 1'b0;
  logic       consume = 1'b0;
  logic [7:0] value = '0;

  logic [23:0] s0, s1, s2;
  logic [39:0] s3;
  logic [2:0]  v0, v1, v2;
  logic [4:0]  v3;
  logic [1:0]  c0, c1, c2;
  logic [2:0]  c3;
  logic [3:0]  rdy, fl, dn, ov;

  operand_collector #(.WIDTH(8), .DEPTH(3), .MODE(OVF_OVERWRITE)) u0 (
    .i_clk(clk), .i_reset(reset), .i_put(put), .i_value(value), .o_ready(rdy[0]),
    .i_consume(consume), .o_slots(s0), .o_slot_valid(v0), .o_count(c0),
    .o_full(fl[0]), .o_done(dn[0]), .o_overflow(ov[0]));
  operand_collector #(.WIDTH(8), .DEPTH(3), .MODE(OVF_SHIFT)) u1 (
    .i_clk(clk), .i_reset(reset), .i_put(put), .i_value(value), .o_ready(rdy[1]),
    .i_consume(consume), .o_slots(s1), .o_slot_valid(v1), .o_count(c1),
    .o_full(fl[1]), .o_done(dn[1]), .o_overflow(ov[1]));
  operand_collector #(.WIDTH(8), .DEPTH(3), .MODE(OVF_STALL)) u2 (
    .i_clk(clk), .i_reset(reset), .i_put(put), .i_value(value), .o_ready(rdy[2]),
    .i_consume(consume), .o_slots(s2), .o_slot_valid(v2), .o_count(c2),
    .o_full(fl[2]), .o_done(dn[2]), .o_overflow(ov[2]));
  operand_collector #(.WIDTH(8), .DEPTH(5), .MODE(OVF_SHIFT)) u3 (
    .i_clk(clk), .i_reset(reset), .i_put(put), .i_value(value), .o_ready(rdy[3]),
    .i_consume(consume), .o_slots(s3), .o_slot_valid(v3), .o_count(c3),
    .o_full(fl[3]), .o_done(dn[3]), .o_overflow(ov[3]));

  logic [39:0] o_sl  [4];
  logic [4:0]  o_val [4];
  logic [2:0]  o_cnt [4];
  assign o_sl[0] = 40'(s0);  assign o_sl[1] = 40'(s1);
  assign o_sl[2] = 40'(s2);  assign o_sl[3] = s3;
  assign o_val[0] = 5'(v0);  assign o_val[1] = 5'(v1);
  assign o_val[2] = 5'(v2);  assign o_val[3] = v3;
  assign o_cnt[0] = 3'(c0);  assign o_cnt[1] = 3'(c1);
  assign o_cnt[2] = 3'(c2);  assign o_cnt[3] = c3;

  // Reference model: each collector is an array of stored values plus a fill level.
  int        md   [4][5];
  int        mn   [4];
  bit        movf [4];
  bit        mdone[4];
  int        dep  [4] = '{3, 3, 3, 5};
  ovf_mode_e mmode[4] = '{OVF_OVERWRITE, OVF_SHIFT, OVF_STALL, OVF_SHIFT};

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  task automatic model_step(input int k, input bit p, input int v, input bit c, input bit r);
    if (r) begin
      for (int i = 0; i < 5; i++) md[k][i] = 0;
      mn[k] = 0; movf[k] = 1'b0; mdone[k] = 1'b0;
      return;
    end
    mdone[k] = 1'b0;
    if (c) begin
      mn[k] = 0;
      if (p) begin
        md[k][0] = v; mn[k] = 1; mdone[k] = 1'b1;
      end
    end else if (p) begin
      if (mn[k] < dep[k]) begin
        md[k][mn[k]] = v; mn[k]++; mdone[k] = 1'b1;
      end else begin
        movf[k] = 1'b1;
        if (mmode[k] == OVF_OVERWRITE) begin
          md[k][dep[k]-1] = v; mdone[k] = 1'b1;
        end else if (mmode[k] == OVF_SHIFT) begin
          for (int i = 0; i < dep[k] - 1; i++) md[k][i] = md[k][i+1];
          md[k][dep[k]-1] = v; mdone[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < 4; k++) begin
      logic [63:0] es;
      logic [63:0] ev;
      es = '0;
      for (int i = 0; i < dep[k]; i++) es[i*8 +: 8] = 8'(md[k][i]);
      ev = (64'd1 << mn[k]) - 64'd1;
      chk({tag, ".slots"}, k, 64'(o_sl[k]), es);
      chk({tag, ".valid"}, k, 64'(o_val[k]), ev);
      chk({tag, ".count"}, k, 64'(o_cnt[k]), 64'(mn[k]));
      chk({tag, ".full"}, k, 64'(fl[k]), 64'(mn[k] == dep[k]));
      chk({tag, ".done"}, k, 64'(dn[k]), 64'(mdone[k]));
      chk({tag, ".ovf"}, k, 64'(ov[k]), 64'(movf[k]));
    end
  endtask

  task automatic step(input bit p, input int v, input bit c, input bit r, input string tag);
    @(negedge clk);
    reset = r; put = p; value = 8'(v); consume = c;
    #1;
    if (!r) begin
      for (int k = 0; k < 4; k++)
        chk({tag, ".ready"}, k, 64'(rdy[k]),
            64'(!(mn[k] == dep[k] && mmode[k] == OVF_STALL) || c));
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_step(k, p, v, c, r);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    step(0, 0, 0, 1, "reset");
    step(0, 0, 0, 0, "idle");
    step(1, 'h11, 0, 0, "put11");
    step(1, 'h22, 0, 0, "put22");
    step(1, 'h33, 0, 0, "put33");
    chk("plan_fill_slots", 0, 64'(s0), 64'h332211);
    chk("plan_fill_full", 0, 64'(fl[0]), 64'd1);
    step(1, 'h44, 0, 0, "put44_ovf");
    chk("plan_overwrite", 0, 64'(s0), 64'h442211);
    chk("plan_shift", 1, 64'(s1), 64'h443322);
    chk("plan_stall_slots", 2, 64'(s2), 64'h332211);
    chk("plan_stall_nodone", 2, 64'(dn[2]), 64'd0);
    step(1, 'h55, 1, 0, "consume_put55");
    chk("plan_cp_valid", 2, 64'(v2), 64'd1);
    step(0, 0, 1, 0, "consume");
    chk("plan_ovf_sticky", 0, 64'(ov[0]), 64'd1);
    step(0, 0, 0, 0, "idle2");

    step(0, 0, 0, 1, "reset2");
    step(1, 'hAA, 0, 0, "putAA");
    step(1, 'hBB, 0, 0, "putBB");
    step(0, 0, 0, 1, "reset_midfill");
    step(1, 'hCC, 0, 0, "putCC");
    chk("plan_after_reset", 0, 64'(s0), 64'h0000CC);

    step(0, 0, 0, 1, "reset3");
    for (int i = 1; i <= 7; i++) step(1, i, 0, 0, "put_seq");
    chk("plan_d5_shift", 3, 64'(s3), 64'h0706050403);
    step(0, 0, 0, 0, "idle3");

    for (int n = 0; n < 400; n++) begin
      bit p, c, r;
      p = ($urandom_range(0, 99) < 65);
      c = ($urandom_range(0, 99) < 15);
      r = ($urandom_range(0, 99) < 3);
      step(p, int'($urandom_range(0, 255)), c, r, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
